// File: rtl/demux_stream_pkg.sv
// Shared defaults, channel select encoding and queue state helper.
package demux_stream_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } q_state_e;

  // Queue state is a pure function of occupancy; there is no separate FSM.
  function automatic q_state_e q_state(input int cnt, input int depth);
    if (cnt == 0)          return Q_EMPTY;
    else if (cnt >= depth) return Q_FULL;
    else                   return Q_PARTIAL;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Single-clock FIFO queue: registered head, no bypass, storage not reset.
module stream_fifo
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  q_state_e         w_state;
  logic             w_push;
  logic             w_pop;

  assign w_state = q_state(int'(r_count), DEPTH);
  assign o_full  = (w_state == Q_FULL);
  assign o_empty = (w_state == Q_EMPTY);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // A full queue refuses pushes; popping an empty queue is a no-op.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage write; deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/demux_stream.sv
// 1-to-2 stream demux: routes each accepted word into the queue chosen by in_sel.
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             a_valid,
  output logic [WIDTH-1:0] a_data,
  input  logic             a_ready,
  output logic             b_valid,
  output logic [WIDTH-1:0] b_data,
  input  logic             b_ready,
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);

  logic w_a_full, w_a_empty, w_b_full, w_b_empty;
  logic w_acc, w_push_a, w_push_b;

  // Ready looks only at the selected queue's registered fullness, never at consumer ready.
  assign in_ready = (in_sel == SEL_B) ? !w_b_full : !w_a_full;
  assign w_acc    = in_valid && in_ready;
  assign w_push_a = w_acc && (in_sel == SEL_A);
  assign w_push_b = w_acc && (in_sel == SEL_B);

  assign a_valid = !w_a_empty;
  assign b_valid = !w_b_empty;

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_a),
    .i_pop   (a_ready),
    .i_data  (in_data),
    .o_data  (a_data),
    .o_full  (w_a_full),
    .o_empty (w_a_empty),
    .o_count (a_count)
  );

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_b),
    .i_pop   (b_ready),
    .i_data  (in_data),
    .o_data  (b_data),
    .o_full  (w_b_full),
    .o_empty (w_b_empty),
    .o_count (b_count)
  );

endmodule

// File: tb/tb_demux_stream.sv
// Directed and randomized checks of demux_stream against a queue-based model.
module tb_demux_stream;

  localparam int W  = 16;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk, rst_n;
  logic          in_valid, in_sel, in_ready;
  logic [W-1:0]  in_data;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [W-1:0]  a_data, b_data;
  logic [CW-1:0] a_count, b_count;

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  demux_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Compare all visible outputs with the model's queues.
  task automatic chk_outputs(input string tag);
    chk({tag, ".a_count"}, 32'(a_count), 32'(qa.size()));
    chk({tag, ".b_count"}, 32'(b_count), 32'(qb.size()));
    chk({tag, ".a_valid"}, 32'(a_valid), 32'(qa.size() != 0));
    chk({tag, ".b_valid"}, 32'(b_valid), 32'(qb.size() != 0));
    if (qa.size() != 0) chk({tag, ".a_data"}, 32'(a_data), 32'(qa[0]));
    if (qb.size() != 0) chk({tag, ".b_data"}, 32'(b_data), 32'(qb[0]));
  endtask

  // One cycle: drive, check ready, clock, update model, check outputs.
  task automatic cyc(input logic v, input logic s, input logic [W-1:0] d,
                     input logic ar, input logic br, input string tag);
    logic exp_rdy, acc, pa, pb;
    in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    #1;
    exp_rdy = s ? (qb.size() < D) : (qa.size() < D);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    pa  = ar && (qa.size() != 0);
    pb  = br && (qb.size() != 0);
    @(posedge clk); #1;
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (acc) begin
      if (s) qb.push_back(d);
      else   qa.push_back(d);
    end
    chk_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 0; in_sel = 0; in_data = '0; a_ready = 0; b_ready = 0;
    qa.delete(); qb.delete();
    #1;
    chk_outputs("reset");
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_sel = 0; in_data = '0; a_ready = 0; b_ready = 0;
    #12;
    do_reset();

    // Single word into a appears the next cycle.
    cyc(1, 0, 16'h1234, 0, 0, "t1");
    chk("t1.a_data_const", 32'(a_data), 32'h1234);
    chk("t1.a_count_const", 32'(a_count), 32'd1);
    chk("t1.b_valid_const", 32'(b_valid), 32'd0);

    // Fill a, ready depends only on selected queue, overflow refused.
    do_reset();
    cyc(1, 0, 16'h0001, 0, 0, "t2a");
    cyc(1, 0, 16'h0002, 0, 0, "t2b");
    chk("t2.a_count_const", 32'(a_count), 32'd2);
    in_sel = 0; #1;
    chk("t2.rdy_sel_a", 32'(in_ready), 32'd0);
    in_sel = 1; #1;
    chk("t2.rdy_sel_b", 32'(in_ready), 32'd1);
    cyc(1, 0, 16'h0003, 0, 0, "t2c");
    chk("t2.a_count_hold", 32'(a_count), 32'd2);
    chk("t2.a_data_hold", 32'(a_data), 32'h0001);

    // Push to b while popping a.
    cyc(1, 1, 16'hBEEF, 1, 0, "t3");
    chk("t3.b_data_const", 32'(b_data), 32'hBEEF);
    chk("t3.a_count_const", 32'(a_count), 32'd1);
    chk("t3.a_data_const", 32'(a_data), 32'h0002);

    // Simultaneous push and pop on b with count 1.
    cyc(1, 1, 16'h0005, 0, 1, "t4");
    chk("t4.b_count_const", 32'(b_count), 32'd1);
    chk("t4.b_data_const", 32'(b_data), 32'h0005);

    // Pop on empty queue is harmless.
    cyc(0, 0, 16'h0000, 1, 0, "t5");
    cyc(0, 0, 16'h0000, 1, 0, "t5b");
    chk("t5.a_count_const", 32'(a_count), 32'd0);

    // Asynchronous reset between edges with both queues non-empty.
    cyc(1, 0, 16'h0077, 0, 0, "t6pre");
    chk("t6.pre_nonempty", 32'(a_valid && b_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.a_count", 32'(a_count), 32'd0);
    chk("t6.b_count", 32'(b_count), 32'd0);
    chk("t6.a_valid", 32'(a_valid), 32'd0);
    chk("t6.b_valid", 32'(b_valid), 32'd0);
    chk("t6.in_ready", 32'(in_ready), 32'd1);
    qa.delete(); qb.delete();
    rst_n = 1'b1;

    // First word after reset release is first delivered.
    cyc(1, 0, 16'h00A1, 0, 0, "t7");
    chk("t7.a_data_const", 32'(a_data), 32'h00A1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 1000; i++) begin
      cyc(($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom),
          1'($urandom), 1'($urandom), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
